// File: rtl/uart_pkg.sv
// Shared encodings and constants for the UART packet receiver.
// Framer and handshake state types live here so the bench can name them too.
package uart_pkg;

   localparam int DATA_BITS      = 8;
   localparam int OVERSAMPLE_DEF = 16;

   typedef enum logic [2:0] {
      F_IDLE  = 3'd0,
      F_START = 3'd1,
      F_DATA  = 3'd2,
      F_STOP  = 3'd3,
      F_BREAK = 3'd4
   } framer_state_e;

   typedef enum logic [1:0] {
      H_EMPTY = 2'd0,
      H_FULL  = 2'd1,
      H_DRAIN = 2'd2
   } hs_state_e;

endpackage

// File: rtl/uart_packet_rx_if.sv
// Four-phase byte handshake between the receiver (master) and the loader (slave).
interface uart_packet_rx_if;
   import uart_pkg::*;

   logic                 packet_ready;
   logic [DATA_BITS-1:0] uart_packet;
   logic                 packet_ack;

   modport master (output packet_ready, output uart_packet, input packet_ack);
   modport slave  (input packet_ready, input uart_packet, output packet_ack);

endinterface

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick: one-clock pulse every CLK_HZ/(BAUD*OVERSAMPLE) clocks.
module uart_baud_tick #(
   parameter int CLK_HZ     = 100_000_000,
   parameter int BAUD       = 115200,
   parameter int OVERSAMPLE = 16
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
   localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;

   generate
      if (DIV < 2) begin : g_div_check
         $error("uart_baud_tick: clock divider below 2");
      end
   endgenerate

   logic [CW-1:0] cnt_r;
   logic          tick_r;

   // Divider counter; tick is registered at the wrap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r  <= '0;
         tick_r <= 1'b0;
      end else if (cnt_r == CW'(DIV - 1)) begin
         cnt_r  <= '0;
         tick_r <= 1'b1;
      end else begin
         cnt_r  <= cnt_r + CW'(1);
         tick_r <= 1'b0;
      end
   end

   assign tick = tick_r;

endmodule

// File: rtl/uart_packet_rx.sv
// 8N1 serial receiver delivering each byte over a four-phase ready/ack handshake.
module uart_packet_rx
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = 100_000_000,
   parameter int BAUD       = 115200,
   parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rx,
   uart_packet_rx_if.master  bus,
   output logic              framing_error,
   output logic              overrun
);

   localparam int TW = $clog2(OVERSAMPLE) + 1;
   localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);

   logic [1:0]           sync_r;
   logic                 rx_s;
   logic                 tick_s;
   framer_state_e        fr_r, fr_nx;
   logic [TW-1:0]        tcnt_r, tcnt_nx;
   logic [2:0]           bit_r, bit_nx;
   logic [DATA_BITS-1:0] shift_r, shift_nx;
   logic                 sample_s, deliver_s, ferr_s;
   hs_state_e            hs_r, hs_nx;
   logic                 load_s, ovr_s;
   logic                 ready_r, ferr_r, overrun_r;
   logic [DATA_BITS-1:0] packet_r;

   uart_baud_tick #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OVERSAMPLE)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick_s)
   );

   // Two-flop synchronizer, idle-high reset value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_r <= 2'b11;
      end else begin
         sync_r <= {sync_r[0], rx};
      end
   end

   assign rx_s     = sync_r[1];
   assign sample_s = tick_s && (tcnt_r == ((fr_r == F_START) ? HALF_LAST : FULL_LAST));

   // Framer next-state: tick counter restarts at every sample point
   always_comb begin
      fr_nx     = fr_r;
      tcnt_nx   = tcnt_r;
      bit_nx    = bit_r;
      shift_nx  = shift_r;
      deliver_s = 1'b0;
      ferr_s    = 1'b0;
      if (fr_r == F_START || fr_r == F_DATA || fr_r == F_STOP) begin
         if (sample_s) begin
            tcnt_nx = '0;
         end else if (tick_s) begin
            tcnt_nx = tcnt_r + TW'(1);
         end else begin
            tcnt_nx = tcnt_r;
         end
      end else begin
         tcnt_nx = '0;
      end
      case (fr_r)
         F_IDLE: begin
            if (!rx_s) fr_nx = F_START;
            else       fr_nx = F_IDLE;
         end
         F_START: begin
            if (sample_s && !rx_s) begin
               fr_nx  = F_DATA;
               bit_nx = 3'd0;
            end else if (sample_s) begin
               fr_nx = F_IDLE;
            end else begin
               fr_nx = F_START;
            end
         end
         F_DATA: begin
            if (sample_s) begin
               shift_nx = {rx_s, shift_r[DATA_BITS-1:1]};
               if (bit_r == 3'd7) fr_nx = F_STOP;
               else               bit_nx = bit_r + 3'd1;
            end else begin
               fr_nx = F_DATA;
            end
         end
         F_STOP: begin
            if (sample_s && rx_s) begin
               deliver_s = 1'b1;
               fr_nx     = F_IDLE;
            end else if (sample_s) begin
               ferr_s = 1'b1;
               fr_nx  = F_BREAK;
            end else begin
               fr_nx = F_STOP;
            end
         end
         F_BREAK: begin
            if (rx_s) fr_nx = F_IDLE;
            else      fr_nx = F_BREAK;
         end
         default: fr_nx = F_IDLE;
      endcase
   end

   // Framer state, counters and shift register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fr_r    <= F_IDLE;
         tcnt_r  <= '0;
         bit_r   <= 3'd0;
         shift_r <= '0;
      end else begin
         fr_r    <= fr_nx;
         tcnt_r  <= tcnt_nx;
         bit_r   <= bit_nx;
         shift_r <= shift_nx;
      end
   end

   // Handshake next-state; a delivery outside EMPTY is an overrun
   always_comb begin
      hs_nx  = hs_r;
      load_s = 1'b0;
      ovr_s  = 1'b0;
      case (hs_r)
         H_EMPTY: begin
            if (deliver_s) begin
               load_s = 1'b1;
               hs_nx  = H_FULL;
            end else begin
               hs_nx = H_EMPTY;
            end
         end
         H_FULL: begin
            ovr_s = deliver_s;
            if (bus.packet_ack) hs_nx = H_DRAIN;
            else                hs_nx = H_FULL;
         end
         H_DRAIN: begin
            ovr_s = deliver_s;
            if (!bus.packet_ack) hs_nx = H_EMPTY;
            else                 hs_nx = H_DRAIN;
         end
         default: hs_nx = H_EMPTY;
      endcase
   end

   // Handshake state and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hs_r      <= H_EMPTY;
         ready_r   <= 1'b0;
         packet_r  <= 8'h00;
         ferr_r    <= 1'b0;
         overrun_r <= 1'b0;
      end else begin
         hs_r      <= hs_nx;
         ready_r   <= (hs_nx == H_FULL);
         packet_r  <= load_s ? shift_r : packet_r;
         ferr_r    <= ferr_s;
         overrun_r <= overrun_r | ovr_s;
      end
   end

   assign bus.packet_ready = ready_r;
   assign bus.uart_packet  = packet_r;
   assign framing_error    = ferr_r;
   assign overrun          = overrun_r;

endmodule

// File: tb/tb_uart_packet_rx.sv
// Directed bench: DIV=2, so one bit is 32 clocks; a loader model is stepped every clock.
module tb_uart_packet_rx;
   import uart_pkg::*;

   localparam int BIT_CLKS = 32;

   logic clk = 1'b0;
   logic rst_n;
   logic rx;
   logic framing_error;
   logic overrun;

   int total = 0;
   int bad   = 0;
   int rises = 0;
   int fe_cnt = 0;
   logic prev_ready = 1'b0;
   logic ack_en = 1'b1;
   logic [7:0] got_q[$];

   uart_packet_rx_if bus();

   uart_packet_rx #(.CLK_HZ(3_686_400), .BAUD(115200), .OVERSAMPLE(16)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rx            (rx),
      .bus           (bus),
      .framing_error (framing_error),
      .overrun       (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // one clock: sample at the falling edge, count events, run the loader
   task automatic step();
      @(negedge clk);
      if (bus.packet_ready && !prev_ready) rises++;
      prev_ready = bus.packet_ready;
      if (framing_error) fe_cnt++;
      if (ack_en) begin
         if (bus.packet_ready && !bus.packet_ack) begin
            got_q.push_back(bus.uart_packet);
            bus.packet_ack = 1'b1;
         end else if (bus.packet_ack && !bus.packet_ready) begin
            bus.packet_ack = 1'b0;
         end
      end else begin
         bus.packet_ack = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic bit_time(input logic v);
      rx = v;
      idle(BIT_CLKS);
   endtask

   task automatic send(input logic [7:0] d, input logic stop);
      bit_time(1'b0);
      for (int i = 0; i < 8; i++) bit_time(d[i]);
      bit_time(stop);
   endtask

   initial begin
      int base;
      int r0;
      int f0;
      rst_n = 1'b0;
      rx = 1'b1;
      bus.packet_ack = 1'b0;
      idle(4);
      check("reset_ready", 32'(bus.packet_ready), 32'd0);
      check("reset_packet", 32'(bus.uart_packet), 32'h00);
      check("reset_ferr", 32'(framing_error), 32'd0);
      check("reset_overrun", 32'(overrun), 32'd0);
      rst_n = 1'b1;
      idle(40);

      // single byte with prompt ack
      base = got_q.size(); r0 = rises; f0 = fe_cnt;
      send(8'hA5, 1'b1);
      idle(40);
      check("a5_count", 32'(got_q.size() - base), 32'd1);
      check("a5_byte", 32'(got_q[base]), 32'hA5);
      check("a5_packet", 32'(bus.uart_packet), 32'hA5);
      check("a5_rises", 32'(rises - r0), 32'd1);
      check("a5_ferr", 32'(fe_cnt - f0), 32'd0);
      check("a5_overrun", 32'(overrun), 32'd0);
      check("a5_ready_low", 32'(bus.packet_ready), 32'd0);

      // back-to-back frames
      base = got_q.size();
      send(8'hFF, 1'b1);
      send(8'h00, 1'b1);
      send(8'h00, 1'b1);
      idle(40);
      check("b2b_count", 32'(got_q.size() - base), 32'd3);
      check("b2b_0", 32'(got_q[base]), 32'hFF);
      check("b2b_1", 32'(got_q[base + 1]), 32'h00);
      check("b2b_2", 32'(got_q[base + 2]), 32'h00);
      check("b2b_overrun", 32'(overrun), 32'd0);

      // 4-tick glitch rejected at the start sample
      r0 = rises;
      rx = 1'b0;
      idle(8);
      rx = 1'b1;
      idle(64);
      check("glitch_rises", 32'(rises - r0), 32'd0);
      check("glitch_idle", 32'(dut.fr_r), 32'(F_IDLE));

      // framing error, break, then recovery
      r0 = rises; f0 = fe_cnt;
      send(8'h3C, 1'b0);
      check("ferr_pulse", 32'(fe_cnt - f0), 32'd1);
      check("ferr_no_ready", 32'(rises - r0), 32'd0);
      check("ferr_break", 32'(dut.fr_r), 32'(F_BREAK));
      idle(2 * BIT_CLKS);
      rx = 1'b1;
      idle(2 * BIT_CLKS);
      base = got_q.size();
      send(8'h11, 1'b1);
      idle(40);
      check("recover_count", 32'(got_q.size() - base), 32'd1);
      check("recover_byte", 32'(got_q[base]), 32'h11);
      check("recover_ferr", 32'(fe_cnt - f0), 32'd1);

      // overrun with the loader stalled
      ack_en = 1'b0;
      base = got_q.size();
      send(8'h12, 1'b1);
      idle(20);
      check("stall_ready", 32'(bus.packet_ready), 32'd1);
      check("stall_packet", 32'(bus.uart_packet), 32'h12);
      check("stall_no_overrun", 32'(overrun), 32'd0);
      send(8'h34, 1'b1);
      idle(20);
      check("ovr_set", 32'(overrun), 32'd1);
      check("ovr_packet", 32'(bus.uart_packet), 32'h12);
      check("ovr_ready", 32'(bus.packet_ready), 32'd1);
      ack_en = 1'b1;
      idle(10);
      check("ovr_drain_count", 32'(got_q.size() - base), 32'd1);
      check("ovr_drain_byte", 32'(got_q[base]), 32'h12);
      check("ovr_sticky", 32'(overrun), 32'd1);

      // reset during bit 4 of 0x55
      bit_time(1'b0);
      bit_time(1'b1);
      bit_time(1'b0);
      bit_time(1'b1);
      bit_time(1'b0);
      rx = 1'b1;
      idle(16);
      rst_n = 1'b0;
      idle(3);
      check("mid_rst_ready", 32'(bus.packet_ready), 32'd0);
      check("mid_rst_packet", 32'(bus.uart_packet), 32'h00);
      check("mid_rst_ferr", 32'(framing_error), 32'd0);
      check("mid_rst_overrun", 32'(overrun), 32'd0);
      check("mid_rst_idle", 32'(dut.fr_r), 32'(F_IDLE));
      rst_n = 1'b1;
      r0 = rises;
      idle(2 * BIT_CLKS);
      check("post_rst_quiet", 32'(rises - r0), 32'd0);
      base = got_q.size();
      send(8'h66, 1'b1);
      idle(40);
      check("post_rst_count", 32'(got_q.size() - base), 32'd1);
      check("post_rst_byte", 32'(got_q[base]), 32'h66);
      check("post_rst_packet", 32'(bus.uart_packet), 32'h66);
      check("post_rst_overrun", 32'(overrun), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
